// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the 4-requester round-robin arbiter.
// No logic; imported by rr_pick4 and rr_arbiter4.
package arb_pkg;
  localparam int N_REQ        = 4;
  localparam int ID_W         = 2;
  localparam int MAX_HOLD_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;
endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority picker: first set request scanning from ptr upward, mod 4.
// Purely combinational, zero latency; no flow control.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] pick_onehot,
  output logic [ID_W-1:0]  pick_id,
  output logic             any_req
);

  logic            found;
  logic [ID_W-1:0] idx;

  always_comb begin
    pick_onehot = '0;
    pick_id     = '0;
    found       = 1'b0;
    idx         = '0;
    any_req     = |req;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ptr + ID_W'(k);
      if (!found && req[idx]) begin
        found            = 1'b1;
        pick_id          = idx;
        pick_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter with registered one-hot grant, hold timeout and a forced idle gap.
// Grant appears one edge after req is sampled; owner releases via done, dropping req, or timeout.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [ID_W-1:0]  gnt_id,
  output logic             expired
);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired_q, expired_d;

  logic [N_REQ-1:0] pick_onehot;
  logic [ID_W-1:0]  pick_id;
  logic             any_req;
  logic             rel_done, rel_drop, rel_tmo;

  rr_pick4 u_pick (
    .req         (req),
    .ptr         (ptr_q),
    .pick_onehot (pick_onehot),
    .pick_id     (pick_id),
    .any_req     (any_req)
  );

  assign rel_done = done;
  assign rel_drop = ~req[gnt_id_q];
  assign rel_tmo  = (cnt_q == CNT_W'(MAX_HOLD));

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    expired_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d  = GRANT;
          gnt_d    = pick_onehot;
          gnt_id_d = pick_id;
          cnt_d    = CNT_W'(1);
        end
      end
      GRANT: begin
        // Releasing always passes through IDLE, so the encoder never sees a direct handover.
        if (rel_done || rel_drop || rel_tmo) begin
          state_d   = IDLE;
          gnt_d     = '0;
          gnt_id_d  = '0;
          ptr_d     = gnt_id_q + ID_W'(1);
          cnt_d     = '0;
          expired_d = rel_tmo && !rel_done && !rel_drop;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;
  assign gnt_id    = gnt_id_q;
  assign expired   = expired_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: reset, single grant, rotation, timeout, drop, reset mid-grant.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       expired;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rr_arbiter4 #(.MAX_HOLD(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .expired   (expired)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_gnt(input string tag, input logic [3:0] eg, input logic [1:0] eid,
                         input logic ev, input logic eexp);
    chk({tag, ".gnt"}, gnt, eg);
    chk({tag, ".id"}, gnt_id, eid);
    chk({tag, ".vld"}, gnt_valid, ev);
    chk({tag, ".exp"}, expired, eexp);
  endtask

  logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0] rr_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    rst = 1'b1; req = 4'b1111; done = 1'b0;

    // Reset with all requests pending
    step(); chk_gnt("rst0", 4'b0000, 2'd0, 1'b0, 1'b0);
    step(); chk_gnt("rst1", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step(); chk_gnt("post_rst", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Release by request drop, then single requester 2
    req = 4'b0000;
    step(); chk_gnt("drop0", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b0100;
    step(); chk_gnt("single", 4'b0100, 2'd2, 1'b1, 1'b0);
    done = 1'b1;
    step(); chk_gnt("single_done", 4'b0000, 2'd0, 1'b0, 1'b0);
    done = 1'b0;

    // Rotation from a fresh pointer
    req = 4'b0000; rst = 1'b1;
    step(); rst = 1'b0;
    req = 4'b1111;
    step();
    for (int i = 0; i < 5; i++) begin
      chk_gnt($sformatf("rr%0d", i), rr_exp[i], rr_id[i], 1'b1, 1'b0);
      done = 1'b1;
      step(); chk_gnt($sformatf("rr_gap%0d", i), 4'b0000, 2'd0, 1'b0, 1'b0);
      done = 1'b0;
      if (i < 4) step();
    end

    // Timeout: sole requester 1 held for exactly 8 cycles
    req = 4'b0010;
    step();
    for (int i = 0; i < 8; i++) begin
      chk_gnt($sformatf("hold%0d", i), 4'b0010, 2'd1, 1'b1, 1'b0);
      step();
    end
    chk_gnt("tmo", 4'b0000, 2'd0, 1'b0, 1'b1);
    step(); chk_gnt("tmo_regrant", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Request drop on requester 3, then pointer wrap to 0
    req = 4'b1000;
    step(); chk_gnt("to3_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
    step(); chk_gnt("g3", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b0000;
    step(); chk_gnt("g3_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b1001;
    step(); chk_gnt("wrap", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Reset in the middle of a grant clears the pointer too
    req = 4'b0010;
    step(); chk_gnt("to1_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
    step(); chk_gnt("g1", 4'b0010, 2'd1, 1'b1, 1'b0);
    rst = 1'b1;
    step(); chk_gnt("rst_mid", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0; req = 4'b1111;
    step(); chk_gnt("rst_ptr0", 4'b0001, 2'd0, 1'b1, 1'b0);

    // done coinciding with the timeout cycle suppresses expired
    req = 4'b0001;
    for (int i = 0; i < 7; i++) step();
    chk_gnt("hold_last", 4'b0001, 2'd0, 1'b1, 1'b0);
    done = 1'b1;
    step(); chk_gnt("tmo_done", 4'b0000, 2'd0, 1'b0, 1'b0);
    done = 1'b0;
    step(); chk_gnt("after_tmo_done", 4'b0001, 2'd0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter that sits directly upstream of the 4-to-2 encoder stage.
- Registers a one-hot grant vector. That vector is the encoder's input contract: exactly one bit high, or none.
- Also presents the pre-encoded 2-bit grant index, so downstream logic can take either form.
- Holds each grant until the owner releases it, the owner drops its request, or a hold timeout expires.

Parameters:
- N_REQ, 4, number of requesters. Fixed at 4; any other value is unsupported.
- MAX_HOLD, 8, maximum consecutive cycles one grant may stay asserted. Legal range 2..255.
- CNT_W, 8, width of the hold counter. Must satisfy MAX_HOLD <= 2**CNT_W - 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request lines; req[i] high means requester i wants the resource.
- done  input  1  release pulse from the current owner. Ignored when no grant is active.
- gnt  output  4  registered one-hot grant. All zero when idle.
- gnt_valid  output  1  high when gnt is non-zero.
- gnt_id  output  2  encoded grant index: gnt[0]->00, gnt[1]->01, gnt[2]->10, gnt[3]->11. Forced to 00 when idle.
- expired  output  1  one-cycle pulse on the cycle a grant is force-released by timeout.

Behaviour:
- Reset (rst sampled high at a clock edge):
  - State goes to IDLE.
  - gnt=0000, gnt_valid=0, gnt_id=00, expired=0.
  - Rotating pointer ptr=0, hold counter cnt=0.
  - Reset dominates every other input, including during an active grant: the grant drops at the next edge.
- States: IDLE and GRANT.
- IDLE:
  - If req is non-zero at a clock edge, pick the first set bit scanning ptr, ptr+1, ..., ptr+3 (mod 4).
  - Register the pick into gnt and gnt_id, set gnt_valid=1, set cnt=1, and move to GRANT.
  - Latency: req sampled at edge k produces gnt visible after edge k (one register stage). There is no combinational path from req to gnt.
  - done is ignored in IDLE.
- GRANT: release at the next edge if any of the following holds:
  - (a) done=1;
  - (b) req[gnt_id]=0;
  - (c) cnt==MAX_HOLD.
- On release:
  - gnt=0000, gnt_valid=0, gnt_id=00.
  - ptr = gnt_id+1 (mod 4).
  - cnt=0, state returns to IDLE.
- expired:
  - Pulses high for exactly the release cycle, and only when (c) is the sole cause.
  - If (a) or (b) coincides with (c), expired stays 0.
- Otherwise GRANT holds gnt unchanged and increments cnt.
- Net effect: a grant is visible for at most MAX_HOLD consecutive cycles.
- Handover: grants are never back-to-back. At least one idle cycle (gnt=0000) separates any two grants, even when other requests are pending. This keeps the downstream encoder from ever seeing two hot bits or a glitching transition.
- Fairness:
  - A requester just served has lowest priority on the next pick.
  - With all four requesting continuously, service order is 0,1,2,3,0,...
- Requests arriving or changing during GRANT have no effect except via release cause (b).
- Invariant: gnt is always one-hot or zero; gnt_valid == |gnt; gnt_id equals the encoding of gnt.

Decomposition:
- Shared package arb_pkg holds:
  - the N_REQ and ID_W=2 constants;
  - state encodings IDLE=1'b0, GRANT=1'b1;
  - the default MAX_HOLD.
- One combinational sub-module, rr_pick4, inputs req[3:0] and ptr[1:0], outputs pick_onehot[3:0], pick_id[1:0] and any_req.
- All registers (state, gnt, gnt_id, ptr, cnt, expired) live in rr_arbiter4.

Test Plan:
- Reset: rst=1 for 2 cycles with req=1111 -> gnt=0000, gnt_valid=0, gnt_id=00, expired=0 throughout. After rst falls, gnt=0001 and gnt_id=00 one edge later.
- Single request: req=0100 -> next cycle gnt=0100, gnt_id=10, gnt_valid=1. Pulse done=1 for one cycle -> the following cycle shows gnt=0000.
- Round robin: req=1111 held, done pulsed on each granted cycle -> gnt sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001 with gnt_id 00,01,10,11,00.
- Timeout: MAX_HOLD=8, req=0010 held, done=0 -> gnt=0010 for exactly 8 cycles, then gnt=0000 with expired=1 for one cycle, then re-grant 0010 on the next cycle (sole requester).
- Request drop: grant 1000 active, req[3] falls -> gnt=0000 next cycle, expired=0. Then req=1001 -> gnt=0001 (ptr wrapped to 0).
- Reset mid-grant plus coincident release: assert rst during gnt=0010 -> gnt=0000 next edge and ptr=0. Separately, done=1 on the cycle cnt==MAX_HOLD -> release with expired=0.
